// File: rtl/uart_tx_fifo_cfg_if.sv
// Host-side write port of uart_tx_fifo_cfg: push handshake plus FIFO status.
// The host drives the master side; the transmitter implements the slave side.
interface uart_tx_fifo_cfg_if #(
  parameter int CNT_W = 5
);
  logic             wr_en;
  logic [7:0]       data_in;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  modport master (
    output wr_en, data_in,
    input  fifo_full, fifo_empty, fifo_count, overflow
  );

  modport slave (
    input  wr_en, data_in,
    output fifo_full, fifo_empty, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo_cfg.sv
// Runtime-configurable UART transmitter with an integrated byte FIFO.
// Each FIFO entry becomes one frame: start, 5-8 data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits. Frame settings are latched
// when the entry is popped, so input changes only affect the next frame.
// Optional feature macro: UART_TX_CTS_EN adds an active-low cts_n input
// that gates the start of new frames.
module uart_tx_fifo_cfg #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_fifo_cfg_if.slave bus,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        data_bits,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
`ifdef UART_TX_CTS_EN
  input  logic              cts_n,
`endif
  output logic              tx,
  output logic              tx_busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop, overflow_q;

  // Frame registers
  state_t           state, state_n;
  logic [7:0]       shreg;
  logic [DIV_W-1:0] div_q, baud_cnt;
  logic [1:0]       data_bits_q;
  logic [2:0]       bit_idx, last_idx;
  logic             par_en_q, par_odd_q, stop2_q, par_acc, stop_idx;
  logic             bit_end, cts_ok, tx_n, tx_q;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push     = bus.wr_en && !full;
  assign bit_end  = (baud_cnt == div_q - DIV_W'(1));
  assign last_idx = {1'b0, data_bits_q} + 3'd4;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  // Two-flop synchroniser for the asynchronous clear-to-send input; resets to blocked.
  always_ff @(posedge clk) begin
    if (rst) cts_sync <= 2'b11;
    else     cts_sync <= {cts_sync[0], cts_n};
  end

  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  // FIFO write port.
  // NOTE: the storage array is deliberately not reset; the pointers and
  // occupancy counter define what is valid, and a reset array costs a mux per bit.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  // Pointer, occupancy and overflow-pulse bookkeeping.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= bus.wr_en && full;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state, FIFO pop and next serial level for the current bit.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty && cts_ok) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = shreg[0];
        if (bit_end && bit_idx == last_idx) state_n = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_n = par_acc ^ par_odd_q;
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        tx_n = 1'b1;
        if (bit_end && stop_idx == stop2_q) begin
          // Chain straight into the next frame when one is waiting.
          if (!empty && cts_ok) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Frame datapath: latch entry and settings on pop, then time and shift bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q        <= 1'b1;
      shreg       <= '0;
      div_q       <= DIV_W'(2);
      baud_cnt    <= '0;
      data_bits_q <= '0;
      bit_idx     <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      par_acc     <= 1'b0;
      stop_idx    <= 1'b0;
    end else begin
      tx_q <= tx_n;
      if (pop) begin
        shreg       <= mem[rd_ptr];
        div_q       <= (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
        data_bits_q <= data_bits;
        par_en_q    <= parity_en;
        par_odd_q   <= parity_odd;
        stop2_q     <= stop2;
        baud_cnt    <= '0;
        bit_idx     <= '0;
        par_acc     <= 1'b0;
        stop_idx    <= 1'b0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          baud_cnt <= '0;
          if (state == DATA) begin
            shreg   <= shreg >> 1;
            par_acc <= par_acc ^ shreg[0];
            bit_idx <= bit_idx + 3'd1;
          end
          if (state == STOP) stop_idx <= 1'b1;
        end else begin
          baud_cnt <= baud_cnt + DIV_W'(1);
        end
      end
    end
  end

  assign tx             = tx_q;
  assign tx_busy        = (state != IDLE);
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed testbench for uart_tx_fifo_cfg. Inputs change and outputs are
// sampled 1 ns after each rising edge. Frame bit vectors are written
// LSB = first bit on the wire (start bit).
module tb_uart_tx_fifo_cfg;

  localparam int FIFO_DEPTH = 16;
  localparam int DIV_W      = 16;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] baud_div;
  logic [1:0]       data_bits;
  logic             parity_en, parity_odd, stop2;
  logic             tx, tx_busy;
`ifdef UART_TX_CTS_EN
  logic             cts_n;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  uart_tx_fifo_cfg_if #(.CNT_W(CNT_W)) bus ();

  uart_tx_fifo_cfg #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W     (DIV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .baud_div  (baud_div),
    .data_bits (data_bits),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .stop2     (stop2),
`ifdef UART_TX_CTS_EN
    .cts_n     (cts_n),
`endif
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  // Push one byte; returns 1 ns after the edge that samples wr_en.
  task automatic write_byte(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.data_in = d;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  // Compare tx against a frame for cycles skip..n*div-1, one sample per clock.
  task automatic expect_bits(input string name, input logic [11:0] bits, input int n,
                             input int div, input int skip, output int busy_cnt);
    int errs = 0;
    busy_cnt = 0;
    for (int c = skip; c < n * div; c++) begin
      @(posedge clk); #1;
      if (tx_busy === 1'b1) busy_cnt++;
      if (tx !== bits[c / div] && errs == 0) begin
        $display("FAIL %s: cycle %0d tx=%b expected %b", name, c, tx, bits[c / div]);
        errs++;
      end
    end
    tests_run++;
    if (errs != 0) tests_failed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (tx !== 1'b1) begin $display("FAIL reset_tx: got %b want 1", tx); tests_failed++; end
    tests_run++;
    if (tx_busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", tx_busy); tests_failed++; end
    tests_run++;
    if (bus.fifo_empty !== 1'b1) begin $display("FAIL reset_empty: got %b want 1", bus.fifo_empty); tests_failed++; end
    tests_run++;
    if (bus.fifo_full !== 1'b0) begin $display("FAIL reset_full: got %b want 0", bus.fifo_full); tests_failed++; end
    tests_run++;
    if (bus.fifo_count !== CNT_W'(0)) begin $display("FAIL reset_count: got %0d want 0", bus.fifo_count); tests_failed++; end
    tests_run++;
    if (bus.overflow !== 1'b0) begin $display("FAIL reset_overflow: got %b want 0", bus.overflow); tests_failed++; end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // 8N1, divisor 4, byte 0x55: tx falls two edges after the write, 40-cycle frame.
  task automatic test_basic_8n1();
    int bc;
    baud_div = 16'd4; data_bits = 2'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    write_byte(8'h55);
    tests_run++;
    if (tx !== 1'b1 || bus.fifo_count !== CNT_W'(1)) begin
      $display("FAIL basic_queued: tx=%b count=%0d want tx=1 count=1", tx, bus.fifo_count);
      tests_failed++;
    end
    @(posedge clk); #1;
    tests_run++;
    if (tx !== 1'b1 || tx_busy !== 1'b1 || bus.fifo_empty !== 1'b1) begin
      $display("FAIL basic_pop: tx=%b busy=%b empty=%b want 1 1 1", tx, tx_busy, bus.fifo_empty);
      tests_failed++;
    end
    expect_bits("basic_frame", {2'b00, 1'b1, 8'h55, 1'b0}, 10, 4, 0, bc);
    tests_run++;
    if (bc + 1 != 40) begin $display("FAIL basic_busy_len: got %0d want 40", bc + 1); tests_failed++; end
  endtask

  // 5 data bits, odd parity, 2 stops, divisor 3; settings changed mid-frame.
  task automatic test_parity_odd();
    int bc;
    baud_div = 16'd3; data_bits = 2'd0; parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1;
    write_byte(8'h1F);
    @(posedge clk); #1;
    baud_div = 16'd7; data_bits = 2'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    // 0,1,1,1,1,1, parity 0, stop 1,1
    expect_bits("odd_parity_frame", 12'b0001_1011_1110, 9, 3, 0, bc);
    tests_run++;
    if (bc + 1 != 27) begin $display("FAIL odd_parity_busy_len: got %0d want 27", bc + 1); tests_failed++; end
  endtask

  // 7 data bits, even parity, divisor 2; bit 7 of 0x87 is not transmitted.
  task automatic test_parity_even();
    int bc;
    baud_div = 16'd2; data_bits = 2'd2; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b0;
    write_byte(8'h87);
    @(posedge clk); #1;
    // 0, 1110000, parity 1 (three ones), stop 1
    expect_bits("even_parity_frame", {2'b00, 1'b1, 1'b1, 7'h07, 1'b0}, 10, 2, 0, bc);
  endtask

  // Divisors 0 and 1 both give 2-clock bits.
  task automatic test_min_baud();
    int bc;
    data_bits = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
    baud_div = 16'd0;
    write_byte(8'hA3);
    @(posedge clk); #1;
    expect_bits("baud0_frame", {2'b00, 1'b1, 8'hA3, 1'b0}, 10, 2, 0, bc);
    baud_div = 16'd1;
    write_byte(8'h3C);
    @(posedge clk); #1;
    expect_bits("baud1_frame", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 2, 0, bc);
  endtask

  // Consecutive writes 0x00..0x11. The head entry leaves one edge after the
  // first write, so the 18th write is the one that meets a full FIFO.
  // 17 frames must follow each other with no idle cycles.
  task automatic test_overflow_back_to_back();
    int ovf_pulses = 0;
    int bc;
    baud_div = 16'd100; data_bits = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
    fork
      begin
        for (int k = 0; k < 18; k++) begin
          bus.wr_en   = 1'b1;
          bus.data_in = 8'(k);
          @(posedge clk); #1;
          if (bus.overflow === 1'b1) ovf_pulses++;
          if (k == 16) begin
            tests_run++;
            if (bus.fifo_full !== 1'b1 || bus.fifo_count !== CNT_W'(16)) begin
              $display("FAIL fill_full: full=%b count=%0d want 1 16", bus.fifo_full, bus.fifo_count);
              tests_failed++;
            end
          end
          if (k == 17) begin
            tests_run++;
            if (bus.overflow !== 1'b1) begin $display("FAIL overflow_pulse: got %b want 1", bus.overflow); tests_failed++; end
          end
        end
        bus.wr_en = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          if (bus.overflow === 1'b1) ovf_pulses++;
        end
        tests_run++;
        if (ovf_pulses != 1) begin $display("FAIL overflow_count: got %0d want 1", ovf_pulses); tests_failed++; end
        tests_run++;
        if (bus.fifo_count !== CNT_W'(16)) begin $display("FAIL overflow_kept: count=%0d want 16", bus.fifo_count); tests_failed++; end
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int f = 0; f < 17; f++)
          expect_bits($sformatf("b2b_frame_%0d", f), {2'b00, 1'b1, 8'(f), 1'b0}, 10, 100, 0, bc);
      end
    join
    @(posedge clk); #1;
    tests_run++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || bus.fifo_empty !== 1'b1) begin
      $display("FAIL b2b_drained: tx=%b busy=%b empty=%b want 1 0 1", tx, tx_busy, bus.fifo_empty);
      tests_failed++;
    end
  endtask

  // Reset during DATA of 0xA5 with three entries queued.
  task automatic test_reset_mid_frame();
    int errs = 0;
    baud_div = 16'd4; data_bits = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
    write_byte(8'hA5);
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    tests_run++;
    if (bus.fifo_count !== CNT_W'(3)) begin $display("FAIL midrst_queued: count=%0d want 3", bus.fifo_count); tests_failed++; end
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      $display("FAIL midrst_tx: tx=%b busy=%b want 1 0", tx, tx_busy); tests_failed++;
    end
    tests_run++;
    if (bus.fifo_count !== CNT_W'(0) || bus.fifo_empty !== 1'b1) begin
      $display("FAIL midrst_fifo: count=%0d empty=%b want 0 1", bus.fifo_count, bus.fifo_empty); tests_failed++;
    end
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if ((tx !== 1'b1 || tx_busy !== 1'b0) && errs == 0) begin
        $display("FAIL midrst_quiet: cycle %0d tx=%b busy=%b want 1 0", c, tx, tx_busy);
        errs++;
      end
    end
    tests_run++;
    if (errs != 0) tests_failed++;
  endtask

`ifdef UART_TX_CTS_EN
  // Blocked by cts_n, released, then blocked again mid-frame.
  task automatic test_cts();
    int errs = 0;
    int wait_cycles = 0;
    int bc;
    cts_n = 1'b1;
    baud_div = 16'd2; data_bits = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    write_byte(8'h5A);
    write_byte(8'hC3);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if ((tx !== 1'b1 || tx_busy !== 1'b0) && errs == 0) begin
        $display("FAIL cts_blocked: cycle %0d tx=%b busy=%b want 1 0", c, tx, tx_busy);
        errs++;
      end
    end
    tests_run++;
    if (errs != 0) tests_failed++;
    tests_run++;
    if (bus.fifo_count !== CNT_W'(2)) begin $display("FAIL cts_retained: count=%0d want 2", bus.fifo_count); tests_failed++; end
    cts_n = 1'b0;
    while (wait_cycles < 8) begin
      @(posedge clk); #1;
      wait_cycles++;
      if (tx === 1'b0) break;
    end
    tests_run++;
    if (tx !== 1'b0 || wait_cycles > 4) begin
      $display("FAIL cts_release: tx=%b after %0d cycles want 0 within 4", tx, wait_cycles);
      tests_failed++;
    end else begin
      cts_n = 1'b1;
      expect_bits("cts_frame", {2'b00, 1'b1, 8'h5A, 1'b0}, 10, 2, 1, bc);
      errs = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if ((tx !== 1'b1 || tx_busy !== 1'b0) && errs == 0) begin
          $display("FAIL cts_withheld: cycle %0d tx=%b busy=%b want 1 0", c, tx, tx_busy);
          errs++;
        end
      end
      tests_run++;
      if (errs != 0) tests_failed++;
      tests_run++;
      if (bus.fifo_count !== CNT_W'(1)) begin $display("FAIL cts_second_kept: count=%0d want 1", bus.fifo_count); tests_failed++; end
    end
  endtask
`endif

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.data_in = 8'h00;
    baud_div    = 16'd4;
    data_bits   = 2'd3;
    parity_en   = 1'b0;
    parity_odd  = 1'b0;
    stop2       = 1'b0;
`ifdef UART_TX_CTS_EN
    cts_n       = 1'b0;
`endif
    test_reset();
    test_basic_8n1();
    test_parity_odd();
    test_parity_even();
    test_min_baud();
    test_overflow_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_CTS_EN
    test_cts();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
